// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one step counter between NUM_REQ requesters.
// Optional abort input enabled by defining COUNTER_SCHED_ABORT_EN.
module counter_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int COUNT_FROM = 0,
  parameter int STEP       = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
`ifdef COUNTER_SCHED_ABORT_EN
  input  logic                          abort,
`endif
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] len,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [DATA_WIDTH-1:0] FROM_V = DATA_WIDTH'(COUNT_FROM);
  localparam logic [DATA_WIDTH:0]   STEP_V = (DATA_WIDTH+1)'(STEP);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [DATA_WIDTH-1:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0]   target_q, target_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [IW-1:0]           last_q, last_d;

  logic                    abort_w;
  logic                    pick_valid;
  logic [IW-1:0]           pick_idx;
  logic [DATA_WIDTH-1:0]   pick_len;
  logic [DATA_WIDTH:0]     remain;

`ifdef COUNTER_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Walk downward so the candidate closest above last_q is the one that sticks.
  always_comb begin
    int cand;
    cand       = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  assign pick_len = len[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign remain   = {1'b0, target_q} - {1'b0, count_q};

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    count_d  = count_q;
    target_d = target_q;
    owner_d  = owner_q;
    last_d   = last_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d  = NUM_REQ'(1) << pick_idx;
          owner_d  = pick_idx;
          target_d = pick_len;
          count_d  = FROM_V;
          state_d  = (pick_len <= FROM_V) ? S_DONE : S_COUNT;
        end
      end
      S_COUNT: begin
        if (abort_w || !req[owner_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end else if (en) begin
          if (remain > STEP_V) begin
            count_d = count_q + STEP_V[DATA_WIDTH-1:0];
          end else begin
            count_d = target_q;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        last_d  = owner_q;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      count_q  <= FROM_V;
      target_q <= FROM_V;
      owner_q  <= '0;
      last_q   <= IW'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      count_q  <= count_d;
      target_q <= target_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
    end
  end

  assign grant = grant_q;
  assign busy  = |grant_q;
  assign count = count_q;
  // An abort landing on the done cycle swallows the pulse.
  assign done  = (state_q == S_DONE && !abort_w) ? grant_q : '0;

endmodule
